// File: rtl/decoder_sequencer.sv
// Frame sequencer for the LLR decoder: walks each frame through
// IDLE -> INPUT -> DECODE -> OUTPUT, with an ERROR trap and a software abort.
// Priority is abort first, then error conditions, then normal progress.
module decoder_sequencer #(
    parameter int                     CODE_LENGTH    = 1024,
    parameter int                     STATE_WIDTH    = 10,
    parameter logic [STATE_WIDTH-1:0] IDLE_STATE     = 10'd1,
    parameter logic [STATE_WIDTH-1:0] INPUT_STATE    = 10'd2,
    parameter logic [STATE_WIDTH-1:0] DECODE_STATE   = 10'd4,
    parameter logic [STATE_WIDTH-1:0] OUTPUT_STATE   = 10'd8,
    parameter logic [STATE_WIDTH-1:0] ERROR_STATE    = 10'd16,
    parameter int                     TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   input_write,
    input  logic                   input_error,
    input  logic                   decode_done,
    input  logic                   output_done,
    input  logic                   abort,
    input  logic                   error_clear,
    output logic [STATE_WIDTH-1:0] state,
    output logic                   decode_start,
    output logic                   frame_done,
    output logic                   busy,
    output logic [1:0]             error_code,
    output logic [15:0]            frame_count
);

    // The write counter must be able to hold CODE_LENGTH itself, hence the extra bit.
    localparam int CNT_W = $clog2(CODE_LENGTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Counter values seen during the cycle that finishes INPUT or times out DECODE.
    localparam logic [CNT_W-1:0] LAST_WRITE  = CNT_W'(CODE_LENGTH - 1);
    localparam logic [TO_W-1:0]  LAST_DECODE = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INPUT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_WRITE   = 2'b11;

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [1:0]             error_code_q, error_code_d;
    logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   decode_start_q, decode_start_d;
    logic                   frame_done_q, frame_done_d;
    logic [15:0]            frame_count_q, frame_count_d;

    // State register together with the error code that is tied to it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE_STATE;
            error_code_q <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            error_code_q <= error_code_d;
        end
    end

    // Next-state selection: abort beats errors, errors beat normal progress.
    always_comb begin
        state_d      = state_q;
        error_code_d = error_code_q;
        if (abort && (state_q != IDLE_STATE)) begin
            state_d      = IDLE_STATE;
            error_code_d = ERR_NONE;
        end else begin
            case (state_q)
                IDLE_STATE: begin
                    if (start) state_d = INPUT_STATE;
                end
                INPUT_STATE: begin
                    if (input_error) begin
                        state_d      = ERROR_STATE;
                        error_code_d = ERR_INPUT;
                    end else if (input_write && (wr_cnt_q == LAST_WRITE)) begin
                        state_d = DECODE_STATE;
                    end
                end
                DECODE_STATE: begin
                    if (input_write) begin
                        state_d      = ERROR_STATE;
                        error_code_d = ERR_WRITE;
                    end else if (decode_done) begin
                        state_d = OUTPUT_STATE;
                    end else if (to_cnt_q == LAST_DECODE) begin
                        state_d      = ERROR_STATE;
                        error_code_d = ERR_TIMEOUT;
                    end
                end
                OUTPUT_STATE: begin
                    if (input_write) begin
                        state_d      = ERROR_STATE;
                        error_code_d = ERR_WRITE;
                    end else if (output_done) begin
                        state_d = IDLE_STATE;
                    end
                end
                ERROR_STATE: begin
                    if (error_clear) begin
                        state_d      = IDLE_STATE;
                        error_code_d = ERR_NONE;
                    end
                end
                default: begin
                    state_d      = IDLE_STATE;
                    error_code_d = ERR_NONE;
                end
            endcase
        end
    end

    // Counters and pulse outputs derived from the chosen transition.
    always_comb begin
        wr_cnt_d       = wr_cnt_q;
        to_cnt_d       = '0;
        decode_start_d = 1'b0;
        frame_done_d   = 1'b0;
        frame_count_d  = frame_count_q;

        if ((state_q == INPUT_STATE) && (state_d != IDLE_STATE) && input_write && !input_error) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end else if ((state_d == IDLE_STATE) || (state_q == IDLE_STATE)) begin
            wr_cnt_d = '0;
        end

        if ((state_q == DECODE_STATE) && (state_d == DECODE_STATE)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        decode_start_d = (state_q == INPUT_STATE) && (state_d == DECODE_STATE);
        frame_done_d   = (state_q == OUTPUT_STATE) && (state_d == IDLE_STATE) && !abort;

        if (frame_done_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // Datapath registers behind the outputs and the internal counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_q       <= '0;
            to_cnt_q       <= '0;
            decode_start_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_count_q  <= 16'd0;
        end else begin
            wr_cnt_q       <= wr_cnt_d;
            to_cnt_q       <= to_cnt_d;
            decode_start_q <= decode_start_d;
            frame_done_q   <= frame_done_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign state        = state_q;
    assign decode_start = decode_start_q;
    assign frame_done   = frame_done_q;
    assign busy         = (state_q != IDLE_STATE);
    assign error_code   = error_code_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_decoder_sequencer.sv
// Directed bench for decoder_sequencer with CODE_LENGTH=8, TIMEOUT_CYCLES=16.
// Expected output records are queued as each step is driven and compared after the edge.
module tb_decoder_sequencer;

    localparam logic [9:0] ST_IDLE   = 10'd1;
    localparam logic [9:0] ST_INPUT  = 10'd2;
    localparam logic [9:0] ST_DECODE = 10'd4;
    localparam logic [9:0] ST_OUTPUT = 10'd8;
    localparam logic [9:0] ST_ERROR  = 10'd16;

    // Input bundle bits: {start, input_write, input_error, decode_done, output_done, abort, error_clear}
    localparam logic [6:0] N  = 7'b0000000;
    localparam logic [6:0] S  = 7'b1000000;
    localparam logic [6:0] W  = 7'b0100000;
    localparam logic [6:0] IE = 7'b0010000;
    localparam logic [6:0] DD = 7'b0001000;
    localparam logic [6:0] OD = 7'b0000100;
    localparam logic [6:0] AB = 7'b0000010;
    localparam logic [6:0] EC = 7'b0000001;

    typedef struct packed {
        logic [9:0]  st;
        logic        ds;
        logic        fd;
        logic        bsy;
        logic [1:0]  ec;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, input_write, input_error, decode_done, output_done, abort, error_clear;
    logic [9:0]  state;
    logic        decode_start, frame_done, busy;
    logic [1:0]  error_code;
    logic [15:0] frame_count;

    exp_t        exp_q[$];
    string       tag_q[$];
    logic [15:0] exp_fc = 16'd0;
    int          checks = 0;
    int          failures = 0;

    decoder_sequencer #(
        .CODE_LENGTH   (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .input_write (input_write),
        .input_error (input_error),
        .decode_done (decode_done),
        .output_done (output_done),
        .abort       (abort),
        .error_clear (error_clear),
        .state       (state),
        .decode_start(decode_start),
        .frame_done  (frame_done),
        .busy        (busy),
        .error_code  (error_code),
        .frame_count (frame_count)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [9:0] st, input logic ds, input logic fd, input logic [1:0] ec);
        exp_t e;
        e.st  = st;
        e.ds  = ds;
        e.fd  = fd;
        e.bsy = (st != ST_IDLE);
        e.ec  = ec;
        e.fc  = exp_fc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, "state",        16'(state),        16'(e.st));
        cmp(t, "decode_start", 16'(decode_start), 16'(e.ds));
        cmp(t, "frame_done",   16'(frame_done),   16'(e.fd));
        cmp(t, "busy",         16'(busy),         16'(e.bsy));
        cmp(t, "error_code",   16'(error_code),   16'(e.ec));
        cmp(t, "frame_count",  frame_count,       e.fc);
    endtask

    task automatic applyStimulus(input logic [6:0] in);
        @(negedge clk);
        {start, input_write, input_error, decode_done, output_done, abort, error_clear} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [6:0] in, input logic [9:0] st,
                        input logic ds, input logic fd, input logic [1:0] ec);
        if (fd) exp_fc = exp_fc + 16'd1;
        pushExp(tag, st, ds, fd, ec);
        applyStimulus(in);
        checkOutput();
    endtask

    task automatic toDecode(input string tag);
        step({tag, "_start"}, S, ST_INPUT, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 7; i++) step({tag, "_wr"}, W, ST_INPUT, 1'b0, 1'b0, 2'b00);
        step({tag, "_last_wr"}, W, ST_DECODE, 1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        {start, input_write, input_error, decode_done, output_done, abort, error_clear} = N;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pushExp("reset_vals", ST_IDLE, 1'b0, 1'b0, 2'b00);
        checkOutput();
        @(negedge clk);
        reset = 1'b1;

        // Input error with a simultaneous write, then clear.
        step("ie_start", S, ST_INPUT, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) step("ie_wr", W, ST_INPUT, 1'b0, 1'b0, 2'b00);
        step("ie_err", W | IE, ST_ERROR, 1'b0, 1'b0, 2'b01);
        step("ie_hold_wr", W, ST_ERROR, 1'b0, 1'b0, 2'b01);
        step("ie_clear", EC, ST_IDLE, 1'b0, 1'b0, 2'b00);

        // Normal frame, with start pulses ignored mid-frame.
        toDecode("nf");
        step("nf_dec2_start_ign", S, ST_DECODE, 1'b0, 1'b0, 2'b00);
        step("nf_dec3", N, ST_DECODE, 1'b0, 1'b0, 2'b00);
        step("nf_dec4_start_ign", S, ST_DECODE, 1'b0, 1'b0, 2'b00);
        step("nf_dec5", N, ST_DECODE, 1'b0, 1'b0, 2'b00);
        step("nf_done", DD, ST_OUTPUT, 1'b0, 1'b0, 2'b00);
        step("nf_out_start_ign", S, ST_OUTPUT, 1'b0, 1'b0, 2'b00);
        step("nf_out_done", OD, ST_IDLE, 1'b0, 1'b1, 2'b00);
        step("nf_idle", N, ST_IDLE, 1'b0, 1'b0, 2'b00);
        step("nf_no_queue", N, ST_IDLE, 1'b0, 1'b0, 2'b00);

        // Decode timeout after exactly 16 DECODE cycles.
        toDecode("to");
        for (int i = 0; i < 15; i++) step("to_wait", N, ST_DECODE, 1'b0, 1'b0, 2'b00);
        step("to_expire", N, ST_ERROR, 1'b0, 1'b0, 2'b10);
        step("to_clear", EC, ST_IDLE, 1'b0, 1'b0, 2'b00);

        // decode_done on the 16th cycle wins, then a stray write in OUTPUT.
        toDecode("tw");
        for (int i = 0; i < 15; i++) step("tw_wait", N, ST_DECODE, 1'b0, 1'b0, 2'b00);
        step("tw_done_wins", DD, ST_OUTPUT, 1'b0, 1'b0, 2'b00);
        step("tw_stray_wr", W, ST_ERROR, 1'b0, 1'b0, 2'b11);
        step("tw_err_hold", N, ST_ERROR, 1'b0, 1'b0, 2'b11);
        step("tw_abort_err", AB, ST_IDLE, 1'b0, 1'b0, 2'b00);

        // Abort after three writes, and abort beating an input error.
        step("ab_start", S, ST_INPUT, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) step("ab_wr", W, ST_INPUT, 1'b0, 1'b0, 2'b00);
        step("ab_abort", AB, ST_IDLE, 1'b0, 1'b0, 2'b00);
        step("ab_idle", N, ST_IDLE, 1'b0, 1'b0, 2'b00);
        step("abp_start", S, ST_INPUT, 1'b0, 1'b0, 2'b00);
        step("abp_abort_ie", AB | IE, ST_IDLE, 1'b0, 1'b0, 2'b00);

        // A new frame after abort must need all eight writes again.
        toDecode("aa");
        step("aa_done", DD, ST_OUTPUT, 1'b0, 1'b0, 2'b00);
        step("aa_out_done", OD, ST_IDLE, 1'b0, 1'b1, 2'b00);

        // Asynchronous reset in DECODE, start held during reset is not acted upon.
        toDecode("rs");
        step("rs_dec2", N, ST_DECODE, 1'b0, 1'b0, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        exp_fc = 16'd0;
        pushExp("rs_async", ST_IDLE, 1'b0, 1'b0, 2'b00);
        checkOutput();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        pushExp("rs_hold", ST_IDLE, 1'b0, 1'b0, 2'b00);
        checkOutput();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        #1;
        pushExp("rs_release", ST_IDLE, 1'b0, 1'b0, 2'b00);
        checkOutput();
        toDecode("rf");
        step("rf_done", DD, ST_OUTPUT, 1'b0, 1'b0, 2'b00);
        step("rf_out_done", OD, ST_IDLE, 1'b0, 1'b1, 2'b00);

        // Frame counter wrap from 65535 to 0, preloaded through the counter's next value.
        @(negedge clk);
        {start, input_write, input_error, decode_done, output_done, abort, error_clear} = N;
        force dut.frame_count_d = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_count_d;
        exp_fc = 16'hFFFF;
        pushExp("wr_preload", ST_IDLE, 1'b0, 1'b0, 2'b00);
        checkOutput();
        toDecode("wr");
        step("wr_done", DD, ST_OUTPUT, 1'b0, 1'b0, 2'b00);
        step("wr_out_done", OD, ST_IDLE, 1'b0, 1'b1, 2'b00);
        step("wr_after", N, ST_IDLE, 1'b0, 1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_sequencer.md
DECODER_SEQUENCER -- requirements
Module: decoder_sequencer

Interface
REQ-001 SHALL have parameter CODE_LENGTH, default 1024, the number of LLR writes per frame.
REQ-002 SHALL have parameter STATE_WIDTH, default 10, the width of the state bus.
REQ-003 SHALL have parameters IDLE_STATE=10'd1, INPUT_STATE=10'd2, DECODE_STATE=10'd4, OUTPUT_STATE=10'd8 and ERROR_STATE=10'd16, the one-hot state encodings.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, the maximum number of DECODE cycles allowed.
REQ-005 SHALL have the port: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have the port: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-007 SHALL have the port: start  in  1  frame request, sampled only in IDLE.
REQ-008 SHALL have the port: input_write  in  1  one LLR accepted this cycle (input-side tready&tvalid).
REQ-009 SHALL have the port: input_error  in  1  tlast/length mismatch from the input side.
REQ-010 SHALL have the port: decode_done  in  1  decoder core finished.
REQ-011 SHALL have the port: output_done  in  1  output side finished streaming.
REQ-012 SHALL have the port: abort  in  1  software abort.
REQ-013 SHALL have the port: error_clear  in  1  leave ERROR.
REQ-014 SHALL have the port: state  out  STATE_WIDTH  current state encoding, broadcast to the datapath controllers.
REQ-015 SHALL have the port: decode_start  out  1  single-cycle launch pulse to the decoder core.
REQ-016 SHALL have the port: frame_done  out  1  single-cycle pulse at the end of a frame.
REQ-017 SHALL have the port: busy  out  1  high whenever state != IDLE_STATE.
REQ-018 SHALL have the port: error_code  out  2  00 none, 01 input error, 10 decode timeout, 11 write while not INPUT.
REQ-019 SHALL have the port: frame_count  out  16  number of completed frames.

Function
REQ-020 SHALL have five states: IDLE, INPUT, DECODE, OUTPUT, ERROR; the state output SHALL be registered and SHALL equal the matching parameter.
REQ-021 IDLE SHALL go to INPUT on the first cycle start=1, and SHALL clear the write counter (ADDR width+1 = $clog2(CODE_LENGTH)+1 bits) on that entry.
REQ-022 INPUT SHALL increment the write counter on each input_write=1 cycle.
REQ-023 INPUT SHALL go to DECODE on the cycle in which the CODE_LENGTH-th write is counted.
REQ-024 decode_start SHALL be 1 on exactly the first cycle that state==DECODE_STATE.
REQ-025 DECODE SHALL go to OUTPUT when decode_done=1.
REQ-026 The timeout counter SHALL clear on DECODE entry and increment each DECODE cycle.
REQ-027 Reaching TIMEOUT_CYCLES without decode_done SHALL cause ERROR with code 10.
REQ-028 If decode_done=1 in the same cycle the timeout is reached, done SHALL win.
REQ-029 OUTPUT SHALL go to IDLE when output_done=1.
REQ-030 On the OUTPUT->IDLE transition, frame_done SHALL pulse for 1 cycle and frame_count SHALL increment, wrapping from 65535 to 0.
REQ-031 input_error=1 while in INPUT SHALL cause ERROR with code 01, and SHALL take priority over a simultaneous final write.
REQ-032 input_write=1 in DECODE or OUTPUT SHALL cause ERROR with code 11, and the write SHALL NOT be counted.
REQ-033 input_write in IDLE or ERROR SHALL be ignored.
REQ-034 ERROR SHALL hold state and error_code until error_clear=1, then go to IDLE with error_code=00; frame_count SHALL be unchanged.
REQ-035 abort=1 in any state other than IDLE SHALL go to IDLE next cycle.
REQ-036 Abort SHALL clear the counters, produce no frame_done, leave frame_count unchanged, and clear error_code.
REQ-037 Transition priority SHALL be: abort > error condition > normal transition.
REQ-038 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-039 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-040 reset=0 SHALL immediately force: state=IDLE_STATE, decode_start=0, frame_done=0, busy=0, error_code=00, frame_count=0, and all internal counters=0.
REQ-041 Reset asserted mid-frame SHALL abandon the frame, with no frame_done pulse.
REQ-042 The first transition after deassertion SHALL occur no earlier than the first rising clk edge on which reset=1.

Verification (CODE_LENGTH=8, TIMEOUT_CYCLES=16)
REQ-043 Normal frame: start, 8 writes, decode_done after 5 cycles, output_done -> states 1,2,4,8,1; decode_start pulses once; frame_done pulses once; frame_count=1.
REQ-044 Input error: start, 5 writes, then input_error with a write -> state=16, error_code=01; after error_clear -> state=1, frame_count=0.
REQ-045 Timeout: enter DECODE, hold decode_done=0 -> state=16 after 16 DECODE cycles, error_code=10; a repeat run with decode_done on cycle 16 -> OUTPUT.
REQ-046 Stray write: input_write during OUTPUT -> state=16, error_code=11; start pulses during DECODE/OUTPUT are ignored.
REQ-047 Abort/reset: abort after 3 writes -> IDLE next cycle, frame_count unchanged; reset=0 during DECODE -> all outputs at reset values asynchronously, and a new frame then completes with frame_count=1.
REQ-048 Wrap: preload by running 65536 frames (or force) -> frame_count wraps to 0.
